// File: rtl/piso_serializer_pkg.sv
// Shared types for the parallel-in/serial-out stage.
package piso_serializer_pkg;
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;
endpackage

// File: rtl/piso_serializer_hold_reg.sv
// One-entry holding buffer; parks a word while the shifter is busy.
module piso_hold_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
      full    <= 1'b0;
    end else if (wr_en) begin
      rd_data <= wr_data;
      full    <= 1'b1;
    end else if (rd_en) begin
      full    <= 1'b0;
    end
  end
endmodule

// File: rtl/piso_serializer.sv
// MSB-first serializer with a one-word holding buffer for gapless streaming.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int   WIDTH      = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             SO,
  output logic             so_valid,
  output logic             frame_start,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic             xfer, last, wr_en, rd_en, load_now;
  logic [WIDTH-1:0] load_word;

  assign in_ready = ~hold_full;
  assign xfer     = in_valid & in_ready;
  assign last     = (state == ST_SHIFT) && (cnt == LAST);
  // A word accepted on the last-bit edge bypasses the buffer.
  assign wr_en    = xfer & (state == ST_SHIFT) & ~last;
  assign rd_en    = last & hold_full;

  always_comb begin
    load_word = hold_full ? hold_data : in_data;
    load_now  = 1'b0;
    case (state)
      ST_IDLE:  load_now = xfer;
      ST_SHIFT: load_now = last & (hold_full | xfer);
      default:  load_now = 1'b0;
    endcase
  end

  piso_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (in_data),
    .rd_en   (rd_en),
    .rd_data (hold_data),
    .full    (hold_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      cnt         <= '0;
      SO          <= IDLE_LEVEL;
      so_valid    <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else if (load_now) begin
      state       <= ST_SHIFT;
      shreg       <= load_word;
      cnt         <= '0;
      SO          <= load_word[WIDTH-1];
      so_valid    <= 1'b1;
      frame_start <= 1'b1;
      busy        <= 1'b1;
    end else begin
      case (state)
        ST_SHIFT: begin
          if (!last) begin
            shreg       <= shreg << 1;
            cnt         <= cnt + 1'b1;
            SO          <= shreg[WIDTH-2];
            so_valid    <= 1'b1;
            frame_start <= 1'b0;
            busy        <= 1'b1;
          end else begin
            state       <= ST_IDLE;
            SO          <= IDLE_LEVEL;
            so_valid    <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
          end
        end
        default: begin
          state       <= ST_IDLE;
          SO          <= IDLE_LEVEL;
          so_valid    <= 1'b0;
          frame_start <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// Serializer bench: bit-queue reference model plus directed framing cases.
module tb_piso_serializer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready, SO, so_valid, frame_start, busy;
  logic [W-1:0] sr = '0;

  int checks = 0;
  int errors = 0;

  // Words accepted but not yet started, and bits of the word on the wire.
  logic [W-1:0] wq[$];
  logic         cur[$];
  logic [31:0]  acc;
  bit           accepted;

  piso_serializer #(.WIDTH(W), .IDLE_LEVEL(1'b0)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .SO          (SO),
    .so_valid    (so_valid),
    .frame_start (frame_start),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Downstream LeftShiftRegister: SI fed from SO, shifts every clk.
  always_ff @(posedge clk) sr <= {sr[W-2:0], SO};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs();
    chk("so_valid",    32'(so_valid),    32'(cur.size() > 0));
    chk("SO",          32'(SO),          32'(cur.size() > 0 ? cur[0] : 1'b0));
    chk("frame_start", 32'(frame_start), 32'(cur.size() == W));
    chk("busy",        32'(busy),        32'(cur.size() > 0 || wq.size() > 0));
    chk("in_ready",    32'(in_ready),    32'(wq.size() == 0));
    if (so_valid) acc = {acc[30:0], SO};
  endtask

  task automatic step(input logic v, input logic [W-1:0] d);
    logic [W-1:0] w;
    in_valid = v;
    in_data  = d;
    accepted = v && (wq.size() == 0);
    @(posedge clk);
    if (cur.size() > 0) void'(cur.pop_front());
    if (accepted) wq.push_back(d);
    if (cur.size() == 0 && wq.size() > 0) begin
      w = wq.pop_front();
      for (int i = W - 1; i >= 0; i--) cur.push_back(w[i]);
    end
    @(negedge clk);
    check_outs();
  endtask

  task automatic drain();
    for (int i = 0; i < 3 * W && (cur.size() > 0 || wq.size() > 0); i++) step(1'b0, '0);
    chk("drain_idle", 32'(busy), 32'(0));
  endtask

  initial begin
    #1;
    chk("rst_SO", 32'(SO), 32'(0));
    chk("rst_so_valid", 32'(so_valid), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Single word 1011
    acc = '0;
    step(1'b1, 4'b1011);
    chk("single_fs_first", 32'(frame_start), 32'(1));
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0);
      chk("single_fs_rest", 32'(frame_start), 32'(0));
    end
    step(1'b0, '0);
    chk("single_after", 32'(so_valid), 32'(0));
    chk("single_bits", acc, 32'hB);

    // Back-to-back A then 5
    acc = '0;
    step(1'b1, 4'hA);
    step(1'b1, 4'h5);
    chk("b2b_hold_ready", 32'(in_ready), 32'(0));
    drain();
    chk("b2b_bits", acc, 32'hA5);

    // Hold full: third word waits until first word's last bit
    acc = '0;
    step(1'b1, 4'h9);
    step(1'b1, 4'h6);
    for (int i = 0; i < 3 * W; i++) begin
      step(1'b1, 4'hE);
      if (accepted) break;
    end
    chk("hold_third_accepted", 32'(accepted), 32'(1));
    drain();
    chk("hold_bits", acc, 32'h96E);

    // Last-bit accept: 3 lands on the final bit edge of C
    acc = '0;
    step(1'b1, 4'hC);
    for (int i = 0; i < W - 1; i++) step(1'b0, '0);
    step(1'b1, 4'h3);
    chk("lastbit_no_hold", 32'(in_ready), 32'(1));
    drain();
    chk("lastbit_bits", acc, 32'hC3);

    // Chain into downstream shift register
    step(1'b1, 4'b1101);
    chk("chain_fs", 32'(frame_start), 32'(1));
    for (int i = 0; i < W; i++) step(1'b0, '0);
    chk("chain_sr", 32'(sr), 32'hD);

    // Async reset mid-word with SO high
    step(1'b1, 4'hF);
    step(1'b0, '0);
    chk("prerst_SO", 32'(SO), 32'(1));
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    wq.delete();
    cur.delete();
    chk("midrst_SO", 32'(SO), 32'(0));
    chk("midrst_so_valid", 32'(so_valid), 32'(0));
    chk("midrst_in_ready", 32'(in_ready), 32'(1));
    chk("midrst_busy", 32'(busy), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, '0);

    // Randomized traffic at several offered loads
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 200; i++)
        step(1'($urandom_range(0, 99) < (p == 0 ? 30 : (p == 1 ? 70 : 100))),
             W'($urandom));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
